// File: rtl/aes_block_loader.sv
// aes_block_loader: packs four 32-bit words into one 128-bit block, launches the AES core, streams the result out.
// Latency: aes_ld one cycle after the 4th input word is accepted; out_valid one cycle after aes_done.
// Backpressure: in_ready only while filling; each out_data word is held until out_valid & out_ready.
module aes_block_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         key_we,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text,
  input  logic         aes_done,
  input  logic [127:0] aes_text_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Timeout counter is 8 bits wide, so the limit lives in 1..255.
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t       r_state;
  logic [1:0]   r_idx;
  logic [7:0]   r_cnt;
  logic [127:0] r_key;
  logic [127:0] r_text;
  logic [127:0] r_result;
  logic         r_in_ready;
  logic         r_aes_ld;
  logic         r_out_valid;
  logic         r_busy;
  logic         r_err;

  logic [7:0]   w_cnt_nxt;
  logic [6:0]   w_word_lsb;

  assign w_cnt_nxt  = r_cnt + 8'd1;
  // Word 0 is the most significant: idx 0 -> bits 127:96, idx 3 -> bits 31:0.
  assign w_word_lsb = {~r_idx, 5'd0};

  assign in_ready  = r_in_ready;
  assign aes_ld    = r_aes_ld;
  assign aes_key   = r_key;
  assign aes_text  = r_text;
  assign out_valid = r_out_valid;
  assign out_data  = r_result[w_word_lsb +: 32];
  assign busy      = r_busy;
  assign err       = r_err;

  // Control FSM with registered handshake/status outputs; key and block registers ride along.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state     <= S_FILL;
      r_idx       <= 2'd0;
      r_cnt       <= 8'd0;
      r_key       <= '0;
      r_text      <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_aes_ld    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_aes_ld <= 1'b0;
      // The key may only change while the core is not using it.
      if (key_we && !r_busy) begin
        r_key <= key_in;
      end
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            r_text[w_word_lsb +: 32] <= in_data;
            if (r_idx == 2'd3) begin
              r_idx      <= 2'd0;
              r_state    <= S_LOAD;
              r_aes_ld   <= 1'b1;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT;
          r_cnt   <= 8'd0;
        end
        S_WAIT: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (aes_done) begin
            r_result    <= aes_text_out;
            r_state     <= S_DRAIN;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == LP_TIMEOUT) begin
              r_err      <= 1'b1;
              r_state    <= S_FILL;
              r_idx      <= 2'd0;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_idx == 2'd3) begin
              r_idx       <= 2'd0;
              r_state     <= S_FILL;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: table of block transactions plus hand sequences
// for key locking, reset mid-operation, timeout and done/timeout collision.
module tb_aes_block_loader;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Main instance (default timeout)
  logic         rst_n, key_we, in_valid, in_ready, aes_ld, aes_done, out_valid, out_ready, busy, err;
  logic [127:0] key_in, aes_key, aes_text, aes_text_out;
  logic [31:0]  in_data, out_data;

  // Core model and manual done sources feed the main instance
  logic         core_done = 1'b0, man_done = 1'b0, core_en = 1'b0;
  logic [127:0] core_text = '0, man_text = '0, core_res = '0;
  int           ld_count = 0;

  assign aes_done     = core_done | man_done;
  assign aes_text_out = man_done ? man_text : core_text;

  aes_block_loader dut (
    .sys_clk(sys_clk), .sys_rst_n(rst_n), .key_we(key_we), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .aes_ld(aes_ld), .aes_key(aes_key), .aes_text(aes_text),
    .aes_done(aes_done), .aes_text_out(aes_text_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err)
  );

  // Short-timeout instance
  logic         t_rst_n, t_key_we, t_in_valid, t_in_ready, t_aes_ld, t_aes_done, t_out_valid, t_out_ready, t_busy, t_err;
  logic [127:0] t_key_in, t_aes_key, t_aes_text, t_aes_text_out;
  logic [31:0]  t_in_data, t_out_data;

  aes_block_loader #(.TIMEOUT_CYCLES(8)) dut_to (
    .sys_clk(sys_clk), .sys_rst_n(t_rst_n), .key_we(t_key_we), .key_in(t_key_in),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
    .aes_ld(t_aes_ld), .aes_key(t_aes_key), .aes_text(t_aes_text),
    .aes_done(t_aes_done), .aes_text_out(t_aes_text_out),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data),
    .busy(t_busy), .err(t_err)
  );

  typedef struct {
    logic [127:0]     key;
    logic [3:0][31:0] w;
    logic [127:0]     res;
    int               stall;
    int               gap;
    logic [127:0]     text;
    logic [3:0][31:0] eo;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] key,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [127:0] res, input int stall, input int gap,
                              input logic [127:0] text,
                              input logic [31:0] o0, input logic [31:0] o1,
                              input logic [31:0] o2, input logic [31:0] o3);
    vec_t v;
    v.key = key; v.res = res; v.stall = stall; v.gap = gap; v.text = text;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.eo[0] = o0; v.eo[1] = o1; v.eo[2] = o2; v.eo[3] = o3;
    return v;
  endfunction

  // Core model: answers each aes_ld 11 cycles later with core_res, and checks out_valid follows done by one cycle
  initial begin
    forever begin
      @(posedge sys_clk); #1;
      if (aes_ld) begin
        ld_count++;
        if (core_en) begin
          repeat (11) @(posedge sys_clk);
          #1;
          core_done = 1'b1;
          core_text = core_res;
          chk("out_valid_before_done", {127'd0, out_valid}, 128'd0);
          @(posedge sys_clk); #1;
          core_done = 1'b0;
          core_text = '0;
          chk("done_to_out_valid", {127'd0, out_valid}, 128'd1);
        end
      end
    end
  end

  task automatic feed(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < v.gap; g++) begin
        in_valid = 1'b0;
        @(posedge sys_clk); #1;
      end
      chk("in_ready_fill", {127'd0, in_ready}, 128'd1);
      in_valid = 1'b1;
      in_data  = v.w[k];
      @(posedge sys_clk); #1;
      if (k < 3) chk("no_early_ld", {127'd0, aes_ld}, 128'd0);
    end
    in_valid = 1'b0;
    chk("ld_at_n_plus_1", {127'd0, aes_ld}, 128'd1);
    chk("aes_text", aes_text, v.text);
    chk("busy_after_fill", {127'd0, busy}, 128'd1);
    chk("in_ready_low_busy", {127'd0, in_ready}, 128'd0);
    @(posedge sys_clk); #1;
    chk("ld_one_cycle", {127'd0, aes_ld}, 128'd0);
  endtask

  task automatic drain(input vec_t v);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("out_valid_arrives", {127'd0, out_valid}, 128'd1);
    chk("key_held", aes_key, v.key);
    chk("text_held", aes_text, v.text);
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      for (int s = 0; s < v.stall; s++) begin
        chk("stall_out_data", {96'd0, out_data}, {96'd0, v.eo[k]});
        @(posedge sys_clk); #1;
      end
      out_ready = 1'b1;
      chk("out_valid_word", {127'd0, out_valid}, 128'd1);
      chk("out_data", {96'd0, out_data}, {96'd0, v.eo[k]});
      @(posedge sys_clk); #1;
      out_ready = 1'b0;
    end
    chk("out_valid_after_drain", {127'd0, out_valid}, 128'd0);
    chk("in_ready_after_drain", {127'd0, in_ready}, 128'd1);
    chk("busy_after_drain", {127'd0, busy}, 128'd0);
  endtask

  task automatic t_fill(input logic [3:0][31:0] w);
    for (int k = 0; k < 4; k++) begin
      chk("t_in_ready", {127'd0, t_in_ready}, 128'd1);
      t_in_valid = 1'b1;
      t_in_data  = w[k];
      @(posedge sys_clk); #1;
    end
    t_in_valid = 1'b0;
    chk("t_ld", {127'd0, t_aes_ld}, 128'd1);
  endtask

  // Safety net against a hung run
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int               ldb;
  logic             ov_seen;
  logic [3:0][31:0] tw;
  logic [3:0][31:0] teo;

  initial begin
    vecs[0] = mk(128'h000102030405060708090a0b0c0d0e0f,
                 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0,
                 128'h00112233445566778899aabbccddeeff,
                 32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a);
    vecs[1] = mk(128'h000102030405060708090a0b0c0d0e0f,
                 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, 0,
                 128'h00112233445566778899aabbccddeeff,
                 32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a);
    vecs[2] = mk(128'h2b7e151628aed2a6abf7158809cf4f3c,
                 32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734,
                 128'h3925841d02dc09fbdc118597196a0b32, 1, 1,
                 128'h3243f6a8885a308d313198a2e0370734,
                 32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32);
    vecs[3] = mk(128'hffffffffffffffffffffffffffffffff,
                 32'ha5a5a5a5, 32'h0000ffff, 32'h12345678, 32'hfedcba98,
                 128'h0123456789abcdeffedcba9876543210, 2, 0,
                 128'ha5a5a5a50000ffff12345678fedcba98,
                 32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210);

    tw[0] = 32'hdeadbeef; tw[1] = 32'h01234567; tw[2] = 32'h89abcdef; tw[3] = 32'hcafef00d;
    teo[0] = 32'h0f0e0d0c; teo[1] = 32'h0b0a0908; teo[2] = 32'h07060504; teo[3] = 32'h03020100;

    rst_n = 1'b0; key_we = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    t_rst_n = 1'b0; t_key_we = 1'b0; t_key_in = '0; t_in_valid = 1'b0; t_in_data = '0;
    t_aes_done = 1'b0; t_aes_text_out = '0; t_out_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;

    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_aes_ld", {127'd0, aes_ld}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", {96'd0, out_data}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_aes_key", aes_key, 128'd0);
    chk("rst_aes_text", aes_text, 128'd0);
    chk("t_rst_aes_key", t_aes_key, 128'd0);
    rst_n = 1'b1;
    t_rst_n = 1'b1;

    // Table of full transactions through the main instance
    core_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_we = 1'b1;
      key_in = vecs[i].key;
      @(posedge sys_clk); #1;
      key_we = 1'b0;
      chk("key_load_fill", aes_key, vecs[i].key);
      core_res = vecs[i].res;
      ldb = ld_count;
      feed(vecs[i]);
      drain(vecs[i]);
      chk("ld_exactly_once", 128'(ld_count), 128'(ldb + 1));
      chk("err_clear", {127'd0, err}, 128'd0);
    end

    // Key locked while busy, then reset mid-WAIT with a stray done afterwards
    core_en = 1'b0;
    key_we = 1'b1;
    key_in = {4{32'h11111111}};
    @(posedge sys_clk); #1;
    key_we = 1'b0;
    chk("key_load_k1", aes_key, {4{32'h11111111}});
    feed(vecs[0]);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("busy_in_wait", {127'd0, busy}, 128'd1);
    key_we = 1'b1;
    key_in = {4{32'h22222222}};
    @(posedge sys_clk); #1;
    key_we = 1'b0;
    chk("key_locked_wait", aes_key, {4{32'h11111111}});
    rst_n = 1'b0;
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_aes_key", aes_key, 128'd0);
    chk("mid_rst_aes_text", aes_text, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    man_text = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    man_done = 1'b1;
    @(posedge sys_clk); #1;
    man_done = 1'b0;
    ov_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ov_seen = ov_seen | out_valid;
      @(posedge sys_clk); #1;
    end
    chk("stray_done_no_output", {127'd0, ov_seen}, 128'd0);
    chk("stray_done_busy", {127'd0, busy}, 128'd0);
    chk("stray_done_out_data", {96'd0, out_data}, 128'd0);
    chk("stray_done_err", {127'd0, err}, 128'd0);
    chk("stray_done_in_ready", {127'd0, in_ready}, 128'd1);

    // Short-timeout instance: done outside WAIT is ignored
    t_aes_text_out = 128'h55555555555555555555555555555555;
    t_aes_done = 1'b1;
    @(posedge sys_clk); #1;
    t_aes_done = 1'b0;
    chk("t_done_in_fill_ignored", {127'd0, t_out_valid}, 128'd0);
    chk("t_done_in_fill_busy", {127'd0, t_busy}, 128'd0);

    // Done on the very cycle the counter would expire: done wins
    t_fill(tw);
    chk("t_aes_text", t_aes_text, 128'hdeadbeef0123456789abcdefcafef00d);
    repeat (8) @(posedge sys_clk);
    #1;
    t_aes_text_out = 128'h0f0e0d0c0b0a09080706050403020100;
    t_aes_done = 1'b1;
    @(posedge sys_clk); #1;
    t_aes_done = 1'b0;
    t_aes_text_out = '0;
    chk("t_coincident_valid", {127'd0, t_out_valid}, 128'd1);
    chk("t_coincident_err", {127'd0, t_err}, 128'd0);
    t_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t_out_data", {96'd0, t_out_data}, {96'd0, teo[k]});
      @(posedge sys_clk); #1;
    end
    t_out_ready = 1'b0;
    chk("t_drain_done", {127'd0, t_out_valid}, 128'd0);

    // Core never answers: err after 8 WAIT cycles, back to FILL, no output
    t_fill(tw);
    ov_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge sys_clk); #1;
      ov_seen = ov_seen | t_out_valid;
    end
    chk("t_err_before_timeout", {127'd0, t_err}, 128'd0);
    chk("t_busy_before_timeout", {127'd0, t_busy}, 128'd1);
    @(posedge sys_clk); #1;
    ov_seen = ov_seen | t_out_valid;
    chk("t_err_timeout", {127'd0, t_err}, 128'd1);
    chk("t_in_ready_timeout", {127'd0, t_in_ready}, 128'd1);
    chk("t_busy_timeout", {127'd0, t_busy}, 128'd0);
    repeat (5) begin
      @(posedge sys_clk); #1;
      ov_seen = ov_seen | t_out_valid;
    end
    chk("t_no_output_timeout", {127'd0, ov_seen}, 128'd0);
    chk("t_err_sticky", {127'd0, t_err}, 128'd1);
    t_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    t_rst_n = 1'b1;
    chk("t_err_reset_clears", {127'd0, t_err}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
